// File: rtl/sseg_scan_if.sv
// sseg_scan_if: host/display bundle for the seven-segment scanner.
//   enable, load, value[15:0], dp[3:0] : host -> scanner (scan control, load strobe, payload)
//   sseg_ca[7:0], sseg_an[3:0]         : scanner -> pins (active-low cathodes / anodes)
//   frame_done                         : scanner -> host (end-of-frame pulse)
interface sseg_scan_if;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [7:0]  sseg_ca;
    logic [3:0]  sseg_an;
    logic        frame_done;

    modport master (
        output enable, load, value, dp,
        input  sseg_ca, sseg_an, frame_done
    );

    modport slave (
        input  enable, load, value, dp,
        output sseg_ca, sseg_an, frame_done
    );
endinterface

// File: rtl/sseg_scan.sv
// sseg_scan: time-multiplexed 4-digit seven-segment driver.
// Each digit gets BLANK_CYCLES dark cycles followed by DIGIT_CYCLES lit cycles;
// a loaded value is held in a pending buffer and only copied into the displayed
// (shadow) buffer at a frame boundary, so a frame never mixes two values.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   bus  : sseg_scan_if.slave (enable, load, value, dp in; sseg_ca, sseg_an, frame_done out)
// Optional build macro: SSEG_LZB_EN enables leading-zero blanking on digits 1..3.
module sseg_scan #(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    sseg_scan_if.slave bus
);

    localparam int unsigned CNT_MAX    = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned DIGIT_LAST = DIGIT_CYCLES - 1;
    localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         digit_q, digit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_end_c;

    logic [15:0]        shadow_val_q, pend_val_q;
    logic [3:0]         shadow_dp_q, pend_dp_q;
    logic               pend_valid_q;

    logic [3:0]         nib_c;
    logic [6:0]         seg_c;
    logic [3:0]         sseg_an_c;
    logic [7:0]         sseg_ca_c;

    // Hex to active-low segments, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // State register: scan state, current digit and per-state cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            digit_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter restarts on every state change so it never overflows.
    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        cnt_d       = cnt_q;
        frame_end_c = 1'b0;
        if (!bus.enable) begin
            state_d = S_IDLE;
            digit_d = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    digit_d = 2'd0;
                    cnt_d   = '0;
                    state_d = (BLANK_CYCLES == 0) ? S_ON : S_BLANK;
                end
                S_BLANK: begin
                    if (cnt_q == CNT_W'(BLANK_LAST)) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (cnt_q == CNT_W'(DIGIT_LAST)) begin
                        digit_d     = digit_q + 2'd1;
                        cnt_d       = '0;
                        state_d     = (BLANK_CYCLES == 0) ? S_ON : S_BLANK;
                        frame_end_c = (digit_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    digit_d = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef SSEG_LZB_EN
    logic [3:0] lead_zero_c;

    // lead_zero_c[n]: nibbles n..3 of the shadow value are all zero; digit 0 never blanks.
    always_comb begin
        lead_zero_c    = 4'b0000;
        lead_zero_c[3] = (shadow_val_q[15:12] == 4'h0);
        lead_zero_c[2] = lead_zero_c[3] && (shadow_val_q[11:8] == 4'h0);
        lead_zero_c[1] = lead_zero_c[2] && (shadow_val_q[7:4] == 4'h0);
    end
`endif

    // Output logic: pin values for the current state, registered below.
    always_comb begin
        sseg_an_c = 4'hF;
        sseg_ca_c = 8'hFF;
        nib_c     = shadow_val_q[{digit_q, 2'b00} +: 4];
        seg_c     = decode(nib_c);
`ifdef SSEG_LZB_EN
        if (lead_zero_c[digit_q]) begin
            seg_c = 7'h7F;
        end
`endif
        if (state_q == S_ON) begin
            sseg_an_c = ~(4'b0001 << digit_q);
            sseg_ca_c = {~shadow_dp_q[digit_q], seg_c};
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.sseg_an    <= 4'hF;
            bus.sseg_ca    <= 8'hFF;
            bus.frame_done <= 1'b0;
        end else begin
            bus.sseg_an    <= sseg_an_c;
            bus.sseg_ca    <= sseg_ca_c;
            bus.frame_done <= frame_end_c;
        end
    end

    // Double buffer: a load coinciding with the frame boundary bypasses pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_val_q <= 16'h0;
            shadow_dp_q  <= 4'h0;
            pend_val_q   <= 16'h0;
            pend_dp_q    <= 4'h0;
            pend_valid_q <= 1'b0;
        end else begin
            if (bus.load) begin
                pend_val_q <= bus.value;
                pend_dp_q  <= bus.dp;
            end
            if (frame_end_c && bus.load) begin
                shadow_val_q <= bus.value;
                shadow_dp_q  <= bus.dp;
                pend_valid_q <= 1'b0;
            end else if (frame_end_c && pend_valid_q) begin
                shadow_val_q <= pend_val_q;
                shadow_dp_q  <= pend_dp_q;
                pend_valid_q <= 1'b0;
            end else if (bus.load) begin
                pend_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan.sv
// tb_sseg_scan: scanner bench with a frame-position model (DIGIT_CYCLES=4, BLANK_CYCLES=2).
module tb_sseg_scan;

    localparam int D     = 4;
    localparam int B     = 2;
    localparam int SLOT  = D + B;
    localparam int FRAME = 4 * SLOT;

    logic clk;
    logic rst;

    sseg_scan_if sif();

    sseg_scan #(
        .DIGIT_CYCLES(D),
        .BLANK_CYCLES(B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model: position within the frame since scanning started.
    bit          m_run;
    int          m_pos;
    logic [15:0] m_sh_v, m_pe_v;
    logic [3:0]  m_sh_dp, m_pe_dp;
    bit          m_pv;
    logic [3:0]  e_an;
    logic [7:0]  e_ca;
    logic        e_fd;
    logic [6:0]  seg7 [16];

    initial begin
        seg7 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    end

    task automatic model_reset();
        m_run = 0; m_pos = 0;
        m_sh_v = 16'h0; m_pe_v = 16'h0; m_sh_dp = 4'h0; m_pe_dp = 4'h0; m_pv = 0;
        e_an = 4'hF; e_ca = 8'hFF; e_fd = 1'b0;
    endtask

    // One clock: outputs reflect the pre-edge position, then the model advances.
    task automatic tick();
        int          dig;
        logic [15:0] upper;
        bit          fe;
        @(posedge clk);
        e_an = 4'hF;
        e_ca = 8'hFF;
        if (m_run && (m_pos % SLOT) >= B) begin
            dig       = m_pos / SLOT;
            e_an[dig] = 1'b0;
            upper     = m_sh_v >> (4 * dig);
            e_ca[7]   = ~m_sh_dp[dig];
            e_ca[6:0] = seg7[upper[3:0]];
`ifdef SSEG_LZB_EN
            if (dig > 0 && upper == 16'h0) e_ca[6:0] = 7'h7F;
`endif
        end
        fe   = m_run && sif.enable && (m_pos == FRAME - 1);
        e_fd = fe;
        if (sif.load) begin
            m_pe_v = sif.value; m_pe_dp = sif.dp; m_pv = 1;
        end
        if (fe && m_pv) begin
            m_sh_v = m_pe_v; m_sh_dp = m_pe_dp; m_pv = 0;
        end
        if (!sif.enable) begin
            m_run = 0; m_pos = 0;
        end else if (!m_run) begin
            m_run = 1; m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        if ({sif.sseg_an, sif.sseg_ca, sif.frame_done} !== {4'hF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_async got an=%h ca=%h fd=%b want an=f ca=ff fd=0",
                     sif.sseg_an, sif.sseg_ca, sif.frame_done);
        end
        vectors++;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({sif.sseg_an, sif.sseg_ca, sif.frame_done} !== {e_an, e_ca, e_fd}) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got an=%h ca=%h fd=%b want an=%h ca=%h fd=%b",
                         cyc, sif.sseg_an, sif.sseg_ca, sif.frame_done, e_an, e_ca, e_fd);
            end
            vectors++;
        end
    endtask

    task automatic test_scan();
        int last_fd = -1;
        int pulses  = 0;
        sif.enable = 1'b1;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            tick();
            if ({sif.sseg_an, sif.sseg_ca, sif.frame_done} !== {e_an, e_ca, e_fd}) begin
                errors++;
                $display("FAIL scan cyc=%0d got an=%h ca=%h fd=%b want an=%h ca=%h fd=%b",
                         cyc, sif.sseg_an, sif.sseg_ca, sif.frame_done, e_an, e_ca, e_fd);
            end
            vectors++;
            if (sif.frame_done === 1'b1) begin
                pulses++;
                if (last_fd >= 0) begin
                    if (cyc - last_fd !== FRAME) begin
                        errors++;
                        $display("FAIL frame_period got %0d want %0d", cyc - last_fd, FRAME);
                    end
                    vectors++;
                end
                last_fd = cyc;
            end
        end
        if (pulses !== 2) begin
            errors++;
            $display("FAIL frame_count got %0d want 2", pulses);
        end
        vectors++;
    endtask

    task automatic test_load_midframe();
        bit          loaded = 0;
        bit          window = 0;
        int          seen   = 0;
        logic [7:0]  want;
        for (int i = 0; i < 3 * FRAME; i++) begin
            sif.load = 1'b0;
            if (!loaded && m_run && m_pos == 10) begin
                sif.load = 1'b1; sif.value = 16'h8A31; sif.dp = 4'b0100; loaded = 1;
            end
            tick();
            if ({sif.sseg_an, sif.sseg_ca, sif.frame_done} !== {e_an, e_ca, e_fd}) begin
                errors++;
                $display("FAIL load_mid cyc=%0d got an=%h ca=%h fd=%b want an=%h ca=%h fd=%b",
                         cyc, sif.sseg_an, sif.sseg_ca, sif.frame_done, e_an, e_ca, e_fd);
            end
            vectors++;
            if (window && seen < FRAME && sif.sseg_an !== 4'hF) begin
                case (sif.sseg_an)
                    4'hE:    want = 8'hF9;
                    4'hD:    want = 8'hB0;
                    4'hB:    want = 8'h08;
                    default: want = 8'h80;
                endcase
                if (sif.sseg_ca !== want) begin
                    errors++;
                    $display("FAIL load_8a31 an=%h got ca=%h want ca=%h", sif.sseg_an, sif.sseg_ca, want);
                end
                vectors++;
            end
            if (window) seen++;
            if (loaded && !window && sif.frame_done === 1'b1) window = 1;
        end
        sif.load = 1'b0;
    endtask

    task automatic test_two_loads();
        int  step   = 0;
        bit  window = 0;
        int  seen   = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            sif.load = 1'b0;
            if (step == 0 && m_run && m_pos == 3) begin
                sif.load = 1'b1; sif.value = 16'h1111; sif.dp = 4'h0; step = 1;
            end else if (step == 1 && m_run && m_pos == 12) begin
                sif.load = 1'b1; sif.value = 16'h2222; sif.dp = 4'h0; step = 2;
            end
            tick();
            if ({sif.sseg_an, sif.sseg_ca, sif.frame_done} !== {e_an, e_ca, e_fd}) begin
                errors++;
                $display("FAIL two_loads cyc=%0d got an=%h ca=%h fd=%b want an=%h ca=%h fd=%b",
                         cyc, sif.sseg_an, sif.sseg_ca, sif.frame_done, e_an, e_ca, e_fd);
            end
            vectors++;
            if (window && seen < FRAME && sif.sseg_an !== 4'hF) begin
                if (sif.sseg_ca !== 8'hA4) begin
                    errors++;
                    $display("FAIL last_load_wins an=%h got ca=%h want ca=a4", sif.sseg_an, sif.sseg_ca);
                end
                vectors++;
            end
            if (window) seen++;
            if (step == 2 && !window && sif.frame_done === 1'b1) window = 1;
        end
        sif.load = 1'b0;
    endtask

    task automatic test_load_at_boundary();
        bit done = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            sif.load = 1'b0;
            if (!done && m_run && m_pos == FRAME - 1) begin
                sif.load  = 1'b1;
                sif.value = 16'($urandom);
                sif.dp    = 4'($urandom);
                done      = 1;
            end
            tick();
            if ({sif.sseg_an, sif.sseg_ca, sif.frame_done} !== {e_an, e_ca, e_fd}) begin
                errors++;
                $display("FAIL load_boundary cyc=%0d got an=%h ca=%h fd=%b want an=%h ca=%h fd=%b",
                         cyc, sif.sseg_an, sif.sseg_ca, sif.frame_done, e_an, e_ca, e_fd);
            end
            vectors++;
        end
        sif.load = 1'b0;
    endtask

    task automatic test_disable();
        int off_cnt = -1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            sif.load = 1'b0;
            if (off_cnt < 0 && m_run && m_pos == 15) off_cnt = 0;
            if (off_cnt >= 0 && off_cnt < 4) begin
                sif.enable = 1'b0;
                if (off_cnt == 1) begin
                    sif.load = 1'b1; sif.value = 16'h5A0C; sif.dp = 4'b1001;
                end
                off_cnt++;
            end else begin
                sif.enable = 1'b1;
            end
            tick();
            if ({sif.sseg_an, sif.sseg_ca, sif.frame_done} !== {e_an, e_ca, e_fd}) begin
                errors++;
                $display("FAIL disable cyc=%0d got an=%h ca=%h fd=%b want an=%h ca=%h fd=%b",
                         cyc, sif.sseg_an, sif.sseg_ca, sif.frame_done, e_an, e_ca, e_fd);
            end
            vectors++;
        end
        sif.load   = 1'b0;
        sif.enable = 1'b1;
    endtask

    task automatic test_lzb();
        sif.enable = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            sif.load = 1'b0;
            if (i == 0) begin
                sif.load = 1'b1; sif.value = 16'h0012; sif.dp = 4'h0;
            end else if (i == 2 * FRAME + 5) begin
                sif.load = 1'b1; sif.value = 16'h0000; sif.dp = 4'h0;
            end
            tick();
            if ({sif.sseg_an, sif.sseg_ca, sif.frame_done} !== {e_an, e_ca, e_fd}) begin
                errors++;
                $display("FAIL lzb cyc=%0d got an=%h ca=%h fd=%b want an=%h ca=%h fd=%b",
                         cyc, sif.sseg_an, sif.sseg_ca, sif.frame_done, e_an, e_ca, e_fd);
            end
            vectors++;
        end
        sif.load = 1'b0;
    endtask

    task automatic test_async_reset();
        bit hit = 0;
        sif.enable = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            sif.load = (i == 0);
            sif.value = 16'hBEEF; sif.dp = 4'hF;
            tick();
            if ({sif.sseg_an, sif.sseg_ca, sif.frame_done} !== {e_an, e_ca, e_fd}) begin
                errors++;
                $display("FAIL pre_reset cyc=%0d got an=%h ca=%h fd=%b want an=%h ca=%h fd=%b",
                         cyc, sif.sseg_an, sif.sseg_ca, sif.frame_done, e_an, e_ca, e_fd);
            end
            vectors++;
            if (m_run && m_pos == 9 && m_sh_v == 16'hBEEF) begin
                hit = 1;
                break;
            end
        end
        sif.load = 1'b0;
        if (!hit) begin
            errors++;
            $display("FAIL reset_setup_timeout got pos=%0d want pos=9 with shadow loaded", m_pos);
        end
        vectors++;
        #2 rst = 1'b0;
        #1;
        if ({sif.sseg_an, sif.sseg_ca, sif.frame_done} !== {4'hF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_on got an=%h ca=%h fd=%b want an=f ca=ff fd=0",
                     sif.sseg_an, sif.sseg_ca, sif.frame_done);
        end
        vectors++;
        model_reset();
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            if ({sif.sseg_an, sif.sseg_ca, sif.frame_done} !== {e_an, e_ca, e_fd}) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got an=%h ca=%h fd=%b want an=%h ca=%h fd=%b",
                         cyc, sif.sseg_an, sif.sseg_ca, sif.frame_done, e_an, e_ca, e_fd);
            end
            vectors++;
            if (sif.sseg_an === 4'hE && sif.sseg_ca !== 8'hC0) begin
                errors++;
                $display("FAIL post_reset_digit0 got ca=%h want ca=c0", sif.sseg_ca);
            end
            if (sif.sseg_an === 4'hE) vectors++;
        end
    endtask

    task automatic test_random();
        logic [15:0] mask;
        for (int i = 0; i < 600; i++) begin
            sif.enable = ($urandom_range(0, 99) < 97);
            sif.load   = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 4))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h0FFF;
                2:       mask = 16'h00FF;
                3:       mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            sif.value = 16'($urandom) & mask;
            sif.dp    = 4'($urandom);
            tick();
            if ({sif.sseg_an, sif.sseg_ca, sif.frame_done} !== {e_an, e_ca, e_fd}) begin
                errors++;
                $display("FAIL random cyc=%0d got an=%h ca=%h fd=%b want an=%h ca=%h fd=%b",
                         cyc, sif.sseg_an, sif.sseg_ca, sif.frame_done, e_an, e_ca, e_fd);
            end
            vectors++;
        end
        sif.load = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        sif.enable = 1'b0;
        sif.load   = 1'b0;
        sif.value  = 16'h0;
        sif.dp     = 4'h0;
        model_reset();
        test_reset();
        test_scan();
        test_load_midframe();
        test_two_loads();
        test_load_at_boundary();
        test_disable();
        test_lzb();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sseg_scan.md
Name: sseg_scan

Overview:
- Time-multiplexed 4-digit seven-segment display driver; sits directly downstream of the system GPIO block and drives the board's gpio_sseg_ca / gpio_sseg_an pins.
- Accepts a 16-bit hex value plus 4 decimal points through a load strobe.
- Double-buffers the value so that display updates occur only on frame boundaries (no tearing).
- Inserts a blanking interval between digits to suppress ghosting.

Parameters:
- DIGIT_CYCLES, 100000, clk cycles each digit is lit (1 ms at 100 MHz); legal range >= 1.
- BLANK_CYCLES, 1000, clk cycles with all anodes off before each digit; 0 skips the BLANK state entirely.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- enable  input  1  1 = scanning runs; 0 = display dark.
- load  input  1  single-cycle strobe; captures value and dp.
- value  input  16  digit n = value[4n+3:4n]; digit 0 is rightmost.
- dp  input  4  dp[n] = decimal point of digit n, 1 = lit.
- sseg_ca  output  8  cathodes, active-low; [0]=a ... [6]=g, [7]=dp.
- sseg_an  output  4  anodes, active-low; an[n] selects digit n.
- frame_done  output  1  one-cycle pulse at the end of digit 3's ON period.

Behaviour:
- Reset (rst=0, async):
  - sseg_an=4'hF, sseg_ca=8'hFF, frame_done=0.
  - state=IDLE, digit=0.
  - shadow and pending value/dp = 0; pending_valid = 0.
- Outputs are registered: the state change in cycle t is visible at the outputs in cycle t+1.
- States:
  - IDLE: all outputs dark.
    - enable=1 -> BLANK with digit=0 (or directly to ON if BLANK_CYCLES=0).
  - BLANK: sseg_an=4'hF, sseg_ca=8'hFF.
    - After BLANK_CYCLES cycles -> ON.
  - ON: sseg_an = ~(1<<digit); sseg_ca = {~shadow_dp[digit], decode(shadow nibble)}.
    - After DIGIT_CYCLES cycles: digit increments with wrap 3->0, then -> BLANK (or ON if BLANK_CYCLES=0).
- Frame boundary (end of ON period for digit 3):
  - frame_done=1 for exactly one cycle.
  - If pending_valid: shadow <= pending and pending_valid cleared.
- One frame = 4*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
- Load handling:
  - load=1 writes pending <= {value, dp} and sets pending_valid.
  - Multiple loads within one frame: last one wins.
  - load in the same cycle as the frame boundary: the incoming value goes straight into shadow, and pending_valid ends at 0.
- enable=0 at any time:
  - Next cycle -> IDLE, outputs dark, digit=0, cycle counter cleared.
  - pending and shadow are preserved.
  - frame_done does not fire for a partial frame.
- Decode table for ca[6:0] (active-low):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
- Counter width is $clog2 of the maximum of the two parameters. The counter cannot overflow: it reloads on every state change.

Optional Feature:
- Macro: SSEG_LZB_EN (leading-zero blanking).
- Defined:
  - Digit n (n=1..3) shows ca[6:0]=7'h7F when all nibbles from n up to 3 of shadow are zero.
  - Digit 0 is never blanked.
  - The anode is still driven, and the dp bit still follows shadow_dp.
- Undefined: all four digits are always decoded; no extra logic is present.

Test Plan (DIGIT_CYCLES=4, BLANK_CYCLES=2, frame = 24 cycles):
- Reset then enable=1, no load -> 2 cycles an=F/ca=FF, then an=E/ca=C0 for 4 cycles; the sequence E,D,B,7 repeats; frame_done pulses every 24 cycles.
- load value=16'h8A31, dp=4'b0100 mid-frame -> current frame is unchanged; next frame shows:
  - digit 0: ca=F9
  - digit 1: ca=B0
  - digit 2: ca=08 (dp lit)
  - digit 3: ca=80
- Two loads in one frame (0x1111, then 0x2222) -> next frame shows 0x2222 only; load coincident with frame_done -> new value is shown in the immediately following frame.
- enable dropped during digit 2 ON -> next cycle an=F/ca=FF with no frame_done; re-enable -> restarts at BLANK, digit 0, same shadow value.
- rst asserted low mid-ON -> an=F/ca=FF and frame_done=0 immediately, without a clock edge; after release, shadow=0 and digit 0 shows ca=C0.
- SSEG_LZB_EN defined, value=16'h0012 -> digits 3 and 2 show ca=FF, digit 1 shows F9, digit 0 shows A4; value=0 -> only digit 0 shows C0.
